// File: rtl/uart_word_ctrl_pkg.sv
// Shared widths, grant encodings and FSM states for the UART word controller.
// Also provides the byte-insert helper used when assembling RX words.
package uart_word_ctrl_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int ADDR_W = 3;

  localparam logic GRANT_TX = 1'b0;
  localparam logic GRANT_RX = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX_WR   = 3'd1,
    S_RX_POP  = 3'd2,
    S_RX_GAP  = 3'd3,
    S_RX_DONE = 3'd4
  } state_t;

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        pos,
                                                 input logic [BYTE_W-1:0] data);
    logic [WORD_W-1:0] res;
    res = word;
    res[pos*BYTE_W +: BYTE_W] = data;
    return res;
  endfunction

endpackage

// File: rtl/uart_timeout_counter.sv
// Per-byte wait counter: clears on demand, counts while enabled, flags LIMIT-1.
// A LIMIT of zero means wait forever, so expired is tied low.
module uart_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  generate
    if (LIMIT == 0) begin : g_forever
      assign expired = 1'b0;
    end else begin : g_limit
      assign expired = (count == CNT_W'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/uart_word_ctrl.sv
// Word-level sequencer in front of a byte-wide UART: TX words go out as four
// byte writes, four RX bytes are gathered into a word; one transaction at a time.
module uart_word_ctrl
  import uart_word_ctrl_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int RX_TIMEOUT     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_req,
  input  logic [WORD_W-1:0] tx_word,
  input  logic              rx_req,
  output logic              ready,
  output logic              rx_valid,
  output logic [WORD_W-1:0] rx_word,
  output logic              rx_err,
  output logic [ADDR_W-1:0] uart_address,
  output logic [BYTE_W-1:0] uart_w_data,
  output logic              uart_we,
  input  logic              uart_full,
  input  logic [BYTE_W-1:0] uart_r_data,
  input  logic              uart_rx_empty,
  output logic              uart_re
);

  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_WORD - 1);
  localparam logic [2:0] NUM_IDX  = 3'(BYTES_PER_WORD);

  state_t            state, state_nx;
  logic [2:0]        idx;
  logic [WORD_W-1:0] tx_buf;
  logic [WORD_W-1:0] rx_asm;
  logic              last_grant;
  logic              grant_rx;
  logic              accept_tx, accept_rx;
  logic              do_write, do_pop;
  logic              rx_timeout, rx_finish;
  logic              tmr_clear, tmr_enable, tmr_expired;

  uart_timeout_counter #(
    .LIMIT(RX_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  assign ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    grant_rx = rx_req && (!tx_req || (last_grant == GRANT_TX));
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (tx_req || rx_req) begin
          state_nx = grant_rx ? S_RX_POP : S_TX_WR;
        end
      end
      S_TX_WR: begin
        if (!uart_full && (idx == LAST_IDX)) begin
          state_nx = S_IDLE;
        end
      end
      S_RX_POP: begin
        if (!uart_rx_empty) begin
          state_nx = S_RX_GAP;
        end else if (tmr_expired) begin
          state_nx = S_RX_DONE;
        end
      end
      S_RX_GAP:  state_nx = (idx == NUM_IDX) ? S_RX_DONE : S_RX_POP;
      S_RX_DONE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    do_write   = (state == S_TX_WR) && !uart_full;
    do_pop     = (state == S_RX_POP) && !uart_rx_empty;
    rx_timeout = (state == S_RX_POP) && uart_rx_empty && tmr_expired;
    rx_finish  = ((state == S_RX_GAP) && (idx == NUM_IDX)) || rx_timeout;
    tmr_enable = (state == S_RX_POP) && uart_rx_empty;
    tmr_clear  = (state != S_RX_POP) || !uart_rx_empty;
    accept_tx  = (state == S_IDLE) && (state_nx == S_TX_WR);
    accept_rx  = (state == S_IDLE) && (state_nx == S_RX_POP);
  end

  // rx_word only changes when a result is published, so a new RX request
  // leaves the previous word visible until its own rx_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      uart_we      <= 1'b0;
      uart_re      <= 1'b0;
      uart_address <= '0;
      uart_w_data  <= '0;
      rx_valid     <= 1'b0;
      rx_err       <= 1'b0;
      rx_word      <= '0;
      rx_asm       <= '0;
      tx_buf       <= '0;
      idx          <= '0;
      last_grant   <= GRANT_TX;
    end else begin
      uart_we  <= do_write;
      uart_re  <= do_pop;
      rx_valid <= rx_finish;
      rx_err   <= rx_timeout;
      if (accept_tx) begin
        tx_buf     <= tx_word;
        idx        <= '0;
        last_grant <= GRANT_TX;
      end
      if (accept_rx) begin
        rx_asm     <= '0;
        idx        <= '0;
        last_grant <= GRANT_RX;
      end
      if (do_write) begin
        uart_address <= idx;
        uart_w_data  <= tx_buf[idx[1:0]*BYTE_W +: BYTE_W];
        idx          <= idx + 3'd1;
      end
      if (do_pop) begin
        rx_asm <= put_byte(rx_asm, idx[1:0], uart_r_data);
        idx    <= idx + 3'd1;
      end
      if (rx_finish) begin
        rx_word <= rx_asm;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_ctrl.sv
// Directed-plus-random bench for uart_word_ctrl with a queue-based UART model.
// Expected bytes, words and grant order come from plain arithmetic on the stimulus.
module tb_uart_word_ctrl;

  localparam int   TMO  = 16;
  localparam logic G_TX = 1'b0;
  localparam logic G_RX = 1'b1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tx_req = 1'b0;
  logic [31:0] tx_word = 32'h0;
  logic        rx_req = 1'b0;
  logic        uart_full = 1'b0;
  logic        uart_rx_empty = 1'b1;
  logic [7:0]  uart_r_data = 8'h00;
  logic        ready, rx_valid, rx_err, uart_we, uart_re;
  logic [31:0] rx_word;
  logic [2:0]  uart_address;
  logic [7:0]  uart_w_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0] rxq[$];
  logic [7:0] popped;
  logic [2:0] we_addr_q[$];
  logic [7:0] we_data_q[$];
  int         we_cyc_q[$];
  logic       grant_q[$];
  int         re_cnt = 0;
  int         rxv_cnt = 0;
  int         rxv_cyc = 0;
  logic [31:0] rxv_word = 32'h0;
  logic       rxv_err = 1'b0;
  bit         overlap_seen = 1'b0;
  bit         full_viol = 1'b0;
  logic       full_at_edge = 1'b0;

  uart_word_ctrl #(
    .BYTES_PER_WORD(4),
    .RX_TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_req       (tx_req),
    .tx_word      (tx_word),
    .rx_req       (rx_req),
    .ready        (ready),
    .rx_valid     (rx_valid),
    .rx_word      (rx_word),
    .rx_err       (rx_err),
    .uart_address (uart_address),
    .uart_w_data  (uart_w_data),
    .uart_we      (uart_we),
    .uart_full    (uart_full),
    .uart_r_data  (uart_r_data),
    .uart_rx_empty(uart_rx_empty),
    .uart_re      (uart_re)
  );

  always #5 clk = ~clk;

  // UART side: pop on the edge that ends a cycle with re high.
  always @(posedge clk) begin
    cyc++;
    full_at_edge = uart_full;
    if (uart_re === 1'b1 && rxq.size() > 0) popped = rxq.pop_front();
  end

  always @(negedge clk) begin
    uart_rx_empty = (rxq.size() == 0);
    uart_r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    if (uart_we === 1'b1) begin
      we_addr_q.push_back(uart_address);
      we_data_q.push_back(uart_w_data);
      we_cyc_q.push_back(cyc);
      if (uart_address == 3'd0) grant_q.push_back(G_TX);
      if (full_at_edge) full_viol = 1'b1;
    end
    if (uart_re === 1'b1) re_cnt++;
    if (uart_we === 1'b1 && uart_re === 1'b1) overlap_seen = 1'b1;
    if (rx_valid === 1'b1) begin
      rxv_cnt++;
      rxv_word = rx_word;
      rxv_err  = rx_err;
      rxv_cyc  = cyc;
      grant_q.push_back(G_RX);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag, output int c);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_ready"}, {31'h0, ready}, 32'h1);
    c = cyc;
  endtask

  task automatic run_tx(input string tag, input logic [31:0] w, input int stall_after);
    int n0, c, base, k;
    wait_ready(tag, c);
    base    = we_addr_q.size();
    tx_word = w;
    tx_req  = 1'b1;
    n0      = cyc;
    tick();
    tx_req  = 1'b0;
    tx_word = $urandom;
    if (stall_after >= 0) begin
      k = 0;
      while (we_addr_q.size() < base + stall_after + 1 && k < 50) begin
        tick();
        k++;
      end
      uart_full = 1'b1;
      repeat (5) tick();
      uart_full = 1'b0;
    end
    wait_ready(tag, c);
    if (stall_after < 0) check($sformatf("%s_latency", tag), c - n0, 5);
    check($sformatf("%s_wecount", tag), we_addr_q.size() - base, 4);
    if (we_addr_q.size() - base == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_addr%0d", tag, i), {29'h0, we_addr_q[base+i]}, i);
        check($sformatf("%s_data%0d", tag, i), {24'h0, we_data_q[base+i]}, (w >> (8*i)) & 32'hFF);
      end
      for (int i = 1; i < 4; i++) begin
        check($sformatf("%s_gap%0d", tag, i), we_cyc_q[base+i] - we_cyc_q[base+i-1],
              (i == stall_after + 1) ? 6 : 1);
      end
    end
  endtask

  task automatic run_rx(input string tag, input logic [31:0] w, input int n);
    int n0, c, re0, v0, k;
    logic [31:0] expw;
    logic [7:0]  b;
    wait_ready(tag, c);
    expw = 32'h0;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      if (i < n) begin
        rxq.push_back(b);
        expw = expw + ({24'h0, b} << (8*i));
      end
    end
    re0    = re_cnt;
    v0     = rxv_cnt;
    rx_req = 1'b1;
    n0     = cyc;
    tick();
    rx_req = 1'b0;
    k = 0;
    while (rxv_cnt == v0 && k < 200) begin
      tick();
      k++;
    end
    check({tag, "_valid_seen"}, rxv_cnt - v0, 1);
    check({tag, "_word"}, rxv_word, expw);
    check({tag, "_err"}, {31'h0, rxv_err}, (n < 4) ? 32'h1 : 32'h0);
    check({tag, "_re_count"}, re_cnt - re0, n);
    if (n == 4) check({tag, "_valid_cycle"}, rxv_cyc - n0, 9);
    wait_ready(tag, c);
    if (n == 4) check({tag, "_ready_cycle"}, c - n0, 10);
    repeat (3) tick();
    check({tag, "_valid_once"}, rxv_cnt - v0, 1);
    check({tag, "_word_held"}, rx_word, expw);
  endtask

  initial begin
    int c, base, g0, k;

    // Reset values
    repeat (3) tick();
    check("rst_ready",    {31'h0, ready},    1);
    check("rst_rx_valid", {31'h0, rx_valid}, 0);
    check("rst_rx_err",   {31'h0, rx_err},   0);
    check("rst_rx_word",  rx_word,           0);
    check("rst_we",       {31'h0, uart_we},  0);
    check("rst_re",       {31'h0, uart_re},  0);
    check("rst_addr",     {29'h0, uart_address}, 0);
    check("rst_wdata",    {24'h0, uart_w_data},  0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", {31'h0, ready}, 1);

    // TX: fixed word, then random words, then a stall after byte1
    run_tx("tx_fixed", 32'h08000901, -1);
    for (int t = 0; t < 3; t++) run_tx($sformatf("tx_rand%0d", t), $urandom, -1);
    run_tx("tx_stall", $urandom, 1);

    // RX: fixed bytes, random words, then a timeout with only two bytes
    run_rx("rx_fixed", 32'h092A0708, 4);
    for (int t = 0; t < 2; t++) run_rx($sformatf("rx_rand%0d", t), $urandom, 4);
    run_rx("rx_timeout", 32'hDEAD0103, 2);
    check("rx_queue_drained", rxq.size(), 0);

    // Reset in the middle of a TX after byte1
    wait_ready("rst_mid", c);
    base    = we_addr_q.size();
    tx_word = $urandom;
    tx_req  = 1'b1;
    tick();
    tx_req  = 1'b0;
    k = 0;
    while (we_addr_q.size() < base + 2 && k < 20) begin
      tick();
      k++;
    end
    check("rst_mid_pre_bytes", we_addr_q.size() - base, 2);
    reset = 1'b1;
    tick();
    check("rst_mid_we",    {31'h0, uart_we},  0);
    check("rst_mid_re",    {31'h0, uart_re},  0);
    check("rst_mid_valid", {31'h0, rx_valid}, 0);
    check("rst_mid_err",   {31'h0, rx_err},   0);
    check("rst_mid_word",  rx_word,           0);
    check("rst_mid_addr",  {29'h0, uart_address}, 0);
    check("rst_mid_wdata", {24'h0, uart_w_data},  0);
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_ready", {31'h0, ready}, 1);
    repeat (10) tick();
    check("rst_mid_no_more_we", we_addr_q.size() - base, 2);

    // Arbitration: both requests held; first tie after reset goes to RX
    for (int i = 0; i < 8; i++) rxq.push_back(8'($urandom_range(0, 255)));
    g0      = grant_q.size();
    tx_word = $urandom;
    tx_req  = 1'b1;
    rx_req  = 1'b1;
    k = 0;
    while (grant_q.size() < g0 + 4 && k < 300) begin
      tick();
      k++;
    end
    tx_req = 1'b0;
    rx_req = 1'b0;
    wait_ready("arb", c);
    repeat (5) tick();
    check("arb_grant_count", grant_q.size() - g0, 4);
    if (grant_q.size() - g0 >= 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("arb_grant%0d", i), {31'h0, grant_q[g0+i]},
              (i % 2 == 0) ? {31'h0, G_RX} : {31'h0, G_TX});
    end
    check("arb_rx_bytes_used", rxq.size(), 0);

    check("no_we_re_overlap",  {31'h0, overlap_seen}, 0);
    check("no_we_while_full",  {31'h0, full_viol},    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
